// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: data width, default bit period, and receiver FSM states.
package uart_rx_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int BAUD_DIV_DEF = 10416;  // 100 MHz / 9600 baud

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input; resets to 1 (idle line).
// Latency 2 cycles; no flow control.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: byte out with one-cycle rx_done, or one-cycle frame_err on a low stop bit.
// Strobe ~9.5 bit times + 4 cycles after the start edge; no backpressure, consumer must take each strobe.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   rs232_rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_done,
  output logic                   rx_busy,
  output logic                   frame_err
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  rx_state_t              state, state_nxt;
  logic                   rx_s, rx_d, fall;
  logic                   armed;
  logic [1:0]             fill;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   data_smp, stop_smp;

  uart_sync2 u_sync (
    .clk   (CLK),
    .rst_n (RSTn),
    .d     (rs232_rx),
    .q     (rx_s)
  );

  assign fall    = rx_d & ~rx_s;
  assign rx_busy = (state != ST_IDLE);

  // fill marks when the synchroniser has flushed its reset value, so a line
  // held low across reset release never looks like a high-then-low start edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_d  <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_d  <= rx_s;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & rx_s);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    data_smp  = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      ST_IDLE:  if (fall && armed) state_nxt = ST_START;
      ST_START: if (cnt == CNT_HALF) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (cnt == CNT_LAST) begin
          data_smp = 1'b1;
          if (bit_idx == 3'd7) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == CNT_LAST) begin
          stop_smp  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= '0;
    end else begin
      if (state_nxt != state || state == ST_IDLE || cnt == CNT_LAST) cnt <= '0;
      else                                                           cnt <= cnt + 1'b1;
      if (data_smp) begin
        shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= stop_smp & rx_s;
      frame_err <= stop_smp & ~rx_s;
      if (stop_smp && rx_s) rx_data <= shreg;
    end
  end

endmodule
